// File: rtl/lpc_sniffer_pkg.sv
// Shared types for the sniffer capture path: drain FSM states and sync byte values.
package lpc_sniffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SYNC,
        ST_SEND
    } drain_state_t;

    localparam logic [7:0] SYNC_OK  = 8'hA5;
    localparam logic [7:0] SYNC_OVF = 8'h5A;

endpackage

// File: rtl/ringbuffer_drain_if.sv
// Ring buffer read port plus the valid/ready byte stream towards the UART transmitter.
interface ringbuffer_drain_if #(
    parameter int DW = 48
);
    logic          rb_empty;
    logic          rb_overflow;
    logic [DW-1:0] rb_read_data;
    logic          rb_read_clock_enable;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    modport master (
        input  rb_empty, rb_overflow, rb_read_data, tx_ready,
        output rb_read_clock_enable, tx_data, tx_valid
    );

    modport slave (
        output rb_empty, rb_overflow, rb_read_data, tx_ready,
        input  rb_read_clock_enable, tx_data, tx_valid
    );
endinterface

// File: rtl/ringbuffer_drain.sv
// Pops one frame at a time from the capture ring buffer and sends it MSB byte first.
// Define RINGBUFFER_DRAIN_SYNC_EN to prefix every frame with an overflow-status sync byte.
module ringbuffer_drain
    import lpc_sniffer_pkg::*;
#(
    parameter int DW = 48,
    parameter int CW = 16
) (
    input  logic               clock,
    input  logic               reset,
    ringbuffer_drain_if.master bus,
    output logic               busy,
    output logic               overflow_sticky,
    output logic [CW-1:0]      frame_count
);
    localparam int NBYTES = DW / 8;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    drain_state_t  state, state_nxt;
    logic [DW-1:0] frame;
    logic [DW-1:0] frame_shifted;
    logic [IW-1:0] idx;
    logic          frame_done;
    logic          sticky_clr;
`ifdef RINGBUFFER_DRAIN_SYNC_EN
    logic [7:0]    sync_byte;
`endif

    assign busy          = (state != ST_IDLE);
    assign frame_done    = (state == ST_SEND) && bus.tx_ready && (idx == LAST_IDX);
    assign frame_shifted = frame << {idx, 3'b000};

    always_ff @(posedge clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Outputs decode from the registered state only, so tx_valid never follows tx_ready.
    always_comb begin
        state_nxt                = state;
        bus.rb_read_clock_enable = 1'b0;
        bus.tx_valid             = 1'b0;
        bus.tx_data              = 8'h00;
        sticky_clr               = 1'b0;
        case (state)
            ST_IDLE:  if (!bus.rb_empty) state_nxt = ST_FETCH;
            ST_FETCH: begin
                bus.rb_read_clock_enable = 1'b1;
                state_nxt                = ST_CAPTURE;
            end
`ifdef RINGBUFFER_DRAIN_SYNC_EN
            ST_CAPTURE: state_nxt = ST_SYNC;
            ST_SYNC: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = sync_byte;
                if (bus.tx_ready) begin
                    sticky_clr = 1'b1;
                    state_nxt  = ST_SEND;
                end
            end
`else
            ST_CAPTURE: state_nxt = ST_SEND;
`endif
            ST_SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = frame_shifted[DW-1 -: 8];
                if (frame_done) begin
                    state_nxt = ST_IDLE;
`ifdef RINGBUFFER_DRAIN_SYNC_EN
                    sticky_clr = 1'b0;
`else
                    sticky_clr = 1'b1;
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            frame           <= '0;
            idx             <= '0;
            frame_count     <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (state == ST_CAPTURE) begin
                frame <= bus.rb_read_data;
                idx   <= '0;
            end else if ((state == ST_SEND) && bus.tx_ready) begin
                idx <= idx + 1'b1;
            end
            if (frame_done) frame_count <= frame_count + 1'b1;
            // A new overflow wins over a same-cycle clear so no loss goes unreported.
            if (bus.rb_overflow)  overflow_sticky <= 1'b1;
            else if (sticky_clr)  overflow_sticky <= 1'b0;
        end
    end

`ifdef RINGBUFFER_DRAIN_SYNC_EN
    // Status is frozen as the frame enters SYNC, including an overflow arriving that cycle.
    always_ff @(posedge clock) begin
        if (!reset)                   sync_byte <= SYNC_OK;
        else if (state == ST_CAPTURE) sync_byte <= (overflow_sticky || bus.rb_overflow) ? SYNC_OVF : SYNC_OK;
    end
`endif

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Randomized bench for ringbuffer_drain with a queue-based ring buffer and byte-stream model.
module tb_ringbuffer_drain;
    import lpc_sniffer_pkg::*;

    localparam int DW = 48;
    localparam int CW = 2;
    localparam int NBYTES = DW / 8;
`ifdef RINGBUFFER_DRAIN_SYNC_EN
    localparam int SYNC_N = 1;
`else
    localparam int SYNC_N = 0;
`endif

    typedef struct {
        logic [7:0] b;
        int         kind;   // 0 data byte, 1 last data byte, 2 sync byte
    } ebyte_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          busy, overflow_sticky;
    logic [CW-1:0] frame_count;

    ringbuffer_drain_if #(.DW(DW)) bus();

    ringbuffer_drain #(.DW(DW), .CW(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .busy            (busy),
        .overflow_sticky (overflow_sticky),
        .frame_count     (frame_count)
    );

    always #5 clock = ~clock;

    int            n_chk = 0, n_fail = 0, cyc = 0, n_pops = 0;
    bit            checking = 0;
    logic [DW-1:0] rbq[$];
    ebyte_t        expq[$];
    logic [7:0]    rx_log[$];
    int            pop_cyc[$];
    logic          m_pop = 0, m_cap = 0, m_sticky = 0;
    int            m_count = 0;
    logic [DW-1:0] m_frame = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, want);
        end
    endtask

    // Compare, service the ring buffer, then advance the model to the next edge.
    always @(negedge clock) begin
        bit     was_idle, clr;
        ebyte_t e;
        cyc++;
        was_idle = !m_pop && !m_cap && (expq.size() == 0);
        if (checking) begin
            chk("pop_strobe", 64'(bus.rb_read_clock_enable), 64'(m_pop));
            chk("busy", 64'(busy), 64'(m_pop || m_cap || (expq.size() != 0)));
            chk("tx_valid", 64'(bus.tx_valid), 64'(expq.size() != 0));
            if (expq.size() != 0) chk("tx_data", 64'(bus.tx_data), 64'(expq[0].b));
            chk("overflow_sticky", 64'(overflow_sticky), 64'(m_sticky));
            chk("frame_count", 64'(frame_count), 64'(m_count % (1 << CW)));
            if (bus.tx_valid === 1'b1 && bus.tx_ready) rx_log.push_back(bus.tx_data);
        end
        if (bus.rb_read_clock_enable === 1'b1) begin
            n_pops++;
            pop_cyc.push_back(cyc);
            if (rbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL pop_on_empty at cycle %0d: got pop, want none", cyc);
            end else begin
                m_frame          = rbq.pop_front();
                bus.rb_read_data = m_frame;
            end
            bus.rb_empty = (rbq.size() == 0);
        end
        if (!reset) begin
            expq.delete();
            m_pop = 0; m_cap = 0; m_sticky = 0; m_count = 0;
        end else begin
            clr = 0;
            if (expq.size() != 0 && bus.tx_ready) begin
                e = expq.pop_front();
                if (e.kind == 1) begin
                    m_count++;
                    if (SYNC_N == 0) clr = 1;
                end
                if (e.kind == 2) clr = 1;
            end
            if (m_cap) begin
                if (SYNC_N != 0)
                    expq.push_back('{(m_sticky || bus.rb_overflow) ? SYNC_OVF : SYNC_OK, 2});
                for (int i = 0; i < NBYTES; i++)
                    expq.push_back('{m_frame[DW-1-8*i -: 8], (i == NBYTES-1) ? 1 : 0});
            end
            if (bus.rb_overflow) m_sticky = 1;
            else if (clr)        m_sticky = 0;
            m_cap = m_pop;
            m_pop = was_idle && !bus.rb_empty;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input logic [DW-1:0] f);
        rbq.push_back(f);
        bus.rb_empty = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((rbq.size() != 0 || m_pop || m_cap || expq.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: got still busy after %0d cycles, want idle", name, budget);
        end
    endtask

    initial begin
        logic [7:0]    ref_b [NBYTES];
        logic [63:0]   r;
        int            p0, k;
        bus.rb_empty = 1'b1; bus.rb_overflow = 1'b0; bus.rb_read_data = '0; bus.tx_ready = 1'b0;
        ref_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
        tick();
        checking = 1;
        chk("reset_tx_data", 64'(bus.tx_data), 64'h0);
        chk("reset_tx_valid", 64'(bus.tx_valid), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_frame_count", 64'(frame_count), 64'h0);
        tick();
        reset = 1'b1;

        // Reset in the middle of a frame abandons it.
        bus.tx_ready = 1'b1;
        push_frame(48'hDEADBEEF0102);
        k = 0;
        while (rx_log.size() < 2 + SYNC_N && k < 50) begin tick(); k++; end
        if (k >= 50) chk("midreset_start_timeout", 64'(rx_log.size()), 64'(2 + SYNC_N));
        reset = 1'b0;
        tick();
        chk("midreset_tx_valid", 64'(bus.tx_valid), 64'h0);
        chk("midreset_busy", 64'(busy), 64'h0);
        chk("midreset_frame_count", 64'(frame_count), 64'h0);
        reset = 1'b1;
        tick();

        // Single frame, known bytes.
        rx_log.delete();
        p0 = n_pops;
        push_frame(48'h0123456789AB);
        wait_idle("single", 100);
        chk("single_nbytes", 64'(rx_log.size()), 64'(NBYTES + SYNC_N));
        for (int i = 0; i < NBYTES; i++)
            if (i + SYNC_N < rx_log.size()) chk("single_byte", 64'(rx_log[i + SYNC_N]), 64'(ref_b[i]));
        chk("single_pops", 64'(n_pops - p0), 64'h1);
        chk("single_frame_count", 64'(frame_count), 64'h1);

        // Back-to-back frames with tx_ready held high.
        rx_log.delete();
        p0 = pop_cyc.size();
        push_frame(48'h111213141516); push_frame(48'h212223242526); push_frame(48'h313233343536);
        wait_idle("b2b", 200);
        chk("b2b_pops", 64'(pop_cyc.size() - p0), 64'h3);
        if (pop_cyc.size() >= p0 + 3) begin
            chk("b2b_gap1", 64'(pop_cyc[p0+1] - pop_cyc[p0]), 64'(NBYTES + 3 + SYNC_N));
            chk("b2b_gap2", 64'(pop_cyc[p0+2] - pop_cyc[p0+1]), 64'(NBYTES + 3 + SYNC_N));
        end
        chk("b2b_bytes", 64'(rx_log.size()), 64'(3 * (NBYTES + SYNC_N)));
        chk("b2b_frame_count", 64'(frame_count), 64'h0);

        // Backpressure: ready one cycle in three.
        p0 = n_pops;
        push_frame(48'hA1A2A3A4A5A6); push_frame(48'hB1B2B3B4B5B6);
        k = 0;
        while ((rbq.size() != 0 || m_pop || m_cap || expq.size() != 0) && k < 300) begin
            bus.tx_ready = (k % 3 == 0);
            tick();
            k++;
        end
        if (k >= 300) chk("bp_timeout", 64'(k), 64'h0);
        bus.tx_ready = 1'b1;
        chk("bp_pops", 64'(n_pops - p0), 64'h2);

        // Overflow pulse while idle, then a frame.
        bus.rb_overflow = 1'b1;
        tick();
        bus.rb_overflow = 1'b0;
        chk("ovf_sticky_set", 64'(overflow_sticky), 64'h1);
        rx_log.delete();
        push_frame(48'hC0C1C2C3C4C5);
        wait_idle("ovf1", 100);
        chk("ovf_sticky_cleared", 64'(overflow_sticky), 64'h0);
`ifdef RINGBUFFER_DRAIN_SYNC_EN
        if (rx_log.size() > 0) chk("ovf_sync_byte", 64'(rx_log[0]), 64'h5A);
        rx_log.delete();
        push_frame(48'hD0D1D2D3D4D5);
        wait_idle("ovf2", 100);
        if (rx_log.size() > 0) chk("ok_sync_byte", 64'(rx_log[0]), 64'hA5);
`endif

        // Random traffic, backpressure and overflow pulses.
        for (int i = 0; i < 800; i++) begin
            bus.tx_ready    = ($urandom_range(0, 3) != 0);
            bus.rb_overflow = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0 && rbq.size() < 4) begin
                r = {$urandom, $urandom};
                push_frame(r[DW-1:0]);
            end
            tick();
        end
        bus.rb_overflow = 1'b0;
        bus.tx_ready    = 1'b1;
        wait_idle("random", 500);

        // Counter wrap: five frames from reset on a 2-bit counter.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) push_frame(DW'(i * 48'h010101010101));
        wait_idle("wrap", 300);
        chk("wrap_frame_count", 64'(frame_count), 64'h1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ringbuffer_drain.md
# ringbuffer_drain

Drain controller for the sniffer's capture ring buffer. Watches the buffer's `empty`/`overflow` flags, pops one DW-bit frame at a time, and serializes it MSB-byte-first onto an 8-bit valid/ready byte stream feeding the UART transmitter. It is the only reader of the ring buffer. It records buffer overflows so host software can detect lost frames.

## Interface
Parameters:
- `DW`, 48, frame width in bits; must be a multiple of 8; `NBYTES = DW/8`.
- `CW`, 16, width of the frame counter.

Ports:
- `clock`  in  1  single clock for the block, rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `rb_empty`  in  1  ring buffer empty flag.
- `rb_overflow`  in  1  ring buffer overflow flag; level.
- `rb_read_data`  in  DW  ring buffer read port data.
- `rb_read_clock_enable`  out  1  one-cycle pop strobe to the ring buffer.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts the byte this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `overflow_sticky`  out  1  an overflow has been seen since the last reported frame.
- `frame_count`  out  CW  number of frames fully sent; wraps modulo 2^CW.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, SYNC (only with macro), SEND.
- IDLE: if `rb_empty`=0, go to FETCH; otherwise stay.
- FETCH: assert `rb_read_clock_enable` for exactly this one cycle, then go to CAPTURE.
- CAPTURE: latch `rb_read_data` into the DW-bit frame register; clear the byte index to 0. Go to SYNC if the macro is defined, else to SEND.
- SYNC: present the sync byte (see Configuration) and hold it until accepted. On acceptance, clear `overflow_sticky` and go to SEND.
- SEND:
  - `tx_data` = frame byte `[DW-1-8*idx -: 8]`, so the MSB byte goes first.
  - On each transfer (`tx_valid`&&`tx_ready`), increment `idx`.
  - On the transfer of byte `NBYTES-1`, increment `frame_count` and go to IDLE.
- Handshake rules:
  - `tx_valid` is high only in SYNC and SEND.
  - Once `tx_valid` rises, `tx_data` stays stable and `tx_valid` stays high until `tx_ready` is seen.
  - `tx_valid` never depends combinationally on `tx_ready`.
- `overflow_sticky` is set on any cycle with `rb_overflow`=1. Set has priority over a same-cycle clear.
- Without the macro, `overflow_sticky` is cleared on completion of each frame.
- The pop strobe is issued only from IDLE→FETCH, so at most one pop is outstanding. The block never pops while a frame is in flight.

## Timing
- Reset values:
  - state IDLE;
  - `rb_read_clock_enable`=0, `tx_valid`=0, `tx_data`=0;
  - `busy`=0, `overflow_sticky`=0, `frame_count`=0.
- Ring buffer read latency is one cycle: data popped in FETCH is valid in CAPTURE.
- Latency from `rb_empty` falling to the first `tx_valid` is 3 cycles: IDLE samples, then FETCH, then CAPTURE. The first byte is presented in the following cycle.
- With `tx_ready` held high, one frame takes NBYTES (+1 with sync) cycles in SEND/SYNC. The block then spends one cycle in IDLE before the next FETCH.
  - Back-to-back period is NBYTES+3 (+1 with sync) cycles.
- Reset asserted mid-frame: the block returns to IDLE next edge. The partially sent frame is abandoned; that entry is already popped and is lost. `frame_count` is not incremented for it.
- `frame_count` wraps from 2^CW−1 to 0 without any flag.

## Configuration
- `RINGBUFFER_DRAIN_SYNC_EN` defined:
  - SYNC state compiled in; each frame is prefixed with one sync byte.
  - Sync byte is `SYNC_OK` (0xA5) if `overflow_sticky`=0 when SYNC is entered, else `SYNC_OVF` (0x5A).
  - The value is fixed on SYNC entry and held while waiting for `tx_ready`.
- Not defined:
  - No SYNC state; the stream is raw frames of NBYTES bytes.
  - Overflow is visible only on the `overflow_sticky` port.

## Structure
- Shared package `lpc_sniffer_pkg`: FSM state enum, `SYNC_OK`/`SYNC_OVF` constants.
- `NBYTES` and the index width `$clog2(NBYTES)` are local parameters of this block.
- Single module; the byte-select mux and FSM are small enough that no sub-module is warranted.

## Test plan
- Single frame, no macro: load buffer with 0x0123456789AB, `tx_ready`=1 → bytes 01,23,45,67,89,AB on consecutive cycles; exactly one pop strobe; `frame_count`=1.
- Backpressure: `tx_ready` toggling 1-of-3 cycles → `tx_data` stable while `tx_valid`=1 and not ready; byte order unchanged; no extra pops.
- Back-to-back: 3 frames queued → 3 pops spaced NBYTES+3 cycles apart; `frame_count`=3; the 18 bytes arrive in order.
- Sync and overflow, macro on: pulse `rb_overflow` for one cycle, then queue a frame → sync byte 0x5A and sticky cleared after acceptance; next frame's sync byte is 0xA5.
- Reset mid-frame: assert `reset` after byte 2 → next cycle `tx_valid`=0, `busy`=0, `frame_count` unchanged; a subsequent frame is sent from byte 0.
- Counter wrap: CW=2, send 5 frames → `frame_count` reads 1.
